// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared definitions for the byte-wide RAM port controller.
//   state_e      : controller FSM states
//   LEN_*        : legal load/store byte counts
//   IO_ADDR_HI   : address bits [17:16] that mark the IO window
//   lastIndex()  : maps a request length onto the index of its final byte
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } state_e;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    localparam logic [1:0] IO_ADDR_HI = 2'b11;

    // A fetch is always a full word, so its final byte index is fixed.
    localparam logic [1:0] FETCH_LAST = 2'd3;

    // Any length other than 1 or 2 (including 0 and 3) runs as a full word.
    function automatic logic [1:0] lastIndex(input logic [2:0] len);
        logic [1:0] idx;
        case (len)
            LEN_B:   idx = 2'd0;
            LEN_H:   idx = 2'd1;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// mem_byte_seq
// Byte sequencer shared by every transaction type: holds the current RAM
// byte address, the index of the byte in flight, and the word being
// assembled from read bytes (little-endian).
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   start_i        : load startAddr_i, clear counter and assembly register
//   startAddr_i    : first byte address of a new transaction
//   step_i         : move to the next byte (address and counter +1)
//   capture_i      : on a step, store din_i into the current byte lane
//   din_i          : RAM read byte
//   byteCnt_o      : index of the byte currently on the bus
//   addr_o         : current RAM byte address (drives mem_a directly)
//   merged_o       : assembled word with din_i placed in the current lane
module mem_byte_seq
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] startAddr_i,
    input  logic                  step_i,
    input  logic                  capture_i,
    input  logic [7:0]            din_i,
    output logic [1:0]            byteCnt_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [31:0]           merged_o
);

    logic [1:0]            byteCnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           assembly_q;

    assign byteCnt_o = byteCnt_q;
    assign addr_o    = addr_q;

    // The final byte of a read is never stored here; the controller takes
    // merged_o straight into its output register on the completing edge.
    always_comb begin
        merged_o = assembly_q;
        merged_o[{byteCnt_q, 3'b000} +: 8] = din_i;
    end

    // Address arithmetic wraps naturally at the top of the address space.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            byteCnt_q  <= 2'd0;
            addr_q     <= '0;
            assembly_q <= 32'd0;
        end else if (start_i) begin
            byteCnt_q  <= 2'd0;
            addr_q     <= startAddr_i;
            assembly_q <= 32'd0;
        end else if (step_i) begin
            byteCnt_q <= byteCnt_q + 2'd1;
            addr_q    <= addr_q + ADDR_WIDTH'(1);
            if (capture_i) begin
                assembly_q <= merged_o;
            end
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl
// Sole master of the byte-wide synchronous RAM port. Arbitrates between the
// instruction fetch unit (32-bit reads) and the load/store unit (1/2/4-byte
// reads and writes, LSU has priority) and runs each access as consecutive
// single-byte RAM cycles, little-endian. All outputs are registered.
// Ports:
//   clk_in, rst_in        : clock, asynchronous active-high reset
//   rdy_in                : global ready, low freezes the controller
//   mem_din/mem_dout      : RAM read byte / write byte
//   mem_a, mem_wr         : RAM byte address, write strobe
//   if_req/if_addr        : fetch request (level) and word address
//   if_flush              : abort an in-flight fetch, block new fetches
//   if_done/if_data       : fetch completion pulse and fetched word
//   ls_req/ls_we/ls_addr  : load/store request, direction, byte address
//   ls_len/ls_wdata       : byte count (1, 2, 4) and store data
//   ls_done/ls_rdata      : completion pulse and zero-extended load data
// Build option MEM_CTRL_IO_STALL_EN adds io_buffer_full: stores into the IO
// window (addr[17:16] == 2'b11) wait while it is high.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_flush,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [2:0]            ls_len,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_done,
    output logic [31:0]           ls_rdata
`ifdef MEM_CTRL_IO_STALL_EN
    ,
    input  logic                  io_buffer_full
`endif
);

    state_e      state_q;
    logic [1:0]  lastIdx_q;
    logic [31:0] wdata_q;
    logic        ifDone_q;
    logic        lsDone_q;
    logic        memWr_q;
    logic [7:0]  memDout_q;
    logic [31:0] ifData_q;
    logic [31:0] lsRdata_q;

    logic [1:0]            seqCnt;
    logic [ADDR_WIDTH-1:0] seqAddr;
    logic [ADDR_WIDTH-1:0] seqStartAddr;
    logic [31:0]           seqMerged;
    logic                  seqStart;
    logic                  seqStep;
    logic                  seqCapture;

    logic       doneBubble;
    logic       acceptLs;
    logic       acceptIf;
    logic       lastByte;
    logic [1:0] nextCnt;
    logic [7:0] nextWrByte;
    logic       stallFirst;
    logic       stallCur;
    logic       stallNext;

    assign mem_dout = memDout_q;
    assign mem_a    = seqAddr;
    assign mem_wr   = memWr_q;
    assign if_done  = ifDone_q;
    assign if_data  = ifData_q;
    assign ls_done  = lsDone_q;
    assign ls_rdata = lsRdata_q;

    // No request is taken while a done pulse is showing, so a requester
    // still holding req on its done cycle is not served twice.
    assign doneBubble = ifDone_q | lsDone_q;
    assign acceptLs   = rdy_in && (state_q == IDLE) && !doneBubble && ls_req;
    assign acceptIf   = rdy_in && (state_q == IDLE) && !doneBubble && !ls_req
                        && if_req && !if_flush;

    assign lastByte   = (seqCnt == lastIdx_q);
    assign nextCnt    = seqCnt + 2'd1;
    assign nextWrByte = wdata_q[{nextCnt, 3'b000} +: 8];

`ifdef MEM_CTRL_IO_STALL_EN
    // Bits [17:16] of mem_a+1 without building the full-width sum.
    logic [1:0] nextHi;
    assign nextHi     = seqAddr[17:16] + {1'b0, &seqAddr[15:0]};
    assign stallFirst = io_buffer_full && (ls_addr[17:16] == IO_ADDR_HI);
    assign stallCur   = io_buffer_full && (seqAddr[17:16] == IO_ADDR_HI);
    assign stallNext  = io_buffer_full && (nextHi == IO_ADDR_HI);
`else
    assign stallFirst = 1'b0;
    assign stallCur   = 1'b0;
    assign stallNext  = 1'b0;
`endif

    // A write byte only counts as done on an edge where it was actually
    // presented with mem_wr high; otherwise the same byte is re-issued.
    assign seqStart     = acceptLs | acceptIf;
    assign seqStartAddr = ls_req ? ls_addr : if_addr;
    assign seqStep      = rdy_in && !lastByte &&
                          (((state_q == IF_RD) && !if_flush) ||
                           (state_q == LS_RD) ||
                           ((state_q == LS_WR) && memWr_q));
    assign seqCapture   = (state_q != LS_WR);

    mem_byte_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_seq (
        .clk_i       (clk_in),
        .rst_i       (rst_in),
        .start_i     (seqStart),
        .startAddr_i (seqStartAddr),
        .step_i      (seqStep),
        .capture_i   (seqCapture),
        .din_i       (mem_din),
        .byteCnt_o   (seqCnt),
        .addr_o      (seqAddr),
        .merged_o    (seqMerged)
    );

    // While rdy_in is low everything holds except the write strobe, which
    // drops so the frozen byte is not written; it is re-issued on resume.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            lastIdx_q <= 2'd0;
            wdata_q   <= 32'd0;
            ifDone_q  <= 1'b0;
            lsDone_q  <= 1'b0;
            memWr_q   <= 1'b0;
            memDout_q <= 8'd0;
            ifData_q  <= 32'd0;
            lsRdata_q <= 32'd0;
        end else if (!rdy_in) begin
            memWr_q <= 1'b0;
        end else begin
            ifDone_q <= 1'b0;
            lsDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (acceptLs) begin
                        lastIdx_q <= lastIndex(ls_len);
                        wdata_q   <= ls_wdata;
                        if (ls_we) begin
                            state_q   <= LS_WR;
                            memDout_q <= ls_wdata[7:0];
                            memWr_q   <= !stallFirst;
                        end else begin
                            state_q <= LS_RD;
                        end
                    end else if (acceptIf) begin
                        state_q   <= IF_RD;
                        lastIdx_q <= FETCH_LAST;
                    end
                end
                IF_RD: begin
                    if (if_flush) begin
                        state_q <= IDLE;
                    end else if (lastByte) begin
                        ifData_q <= seqMerged;
                        ifDone_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                LS_RD: begin
                    if (lastByte) begin
                        lsRdata_q <= seqMerged;
                        lsDone_q  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                LS_WR: begin
                    if (memWr_q) begin
                        if (lastByte) begin
                            lsDone_q  <= 1'b1;
                            memWr_q   <= 1'b0;
                            memDout_q <= 8'd0;
                            state_q   <= IDLE;
                        end else begin
                            memDout_q <= nextWrByte;
                            memWr_q   <= !stallNext;
                        end
                    end else begin
                        memWr_q <= !stallCur;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl
// Directed bench for mem_ctrl with a small byte RAM model. Stimulus changes
// and output checks happen on the falling edge; the RAM presents read data
// for mem_a on the falling edge and commits writes on the rising edge.
module tb_mem_ctrl;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic [7:0]  memDin;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [2:0]  ls_len;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
`ifdef MEM_CTRL_IO_STALL_EN
    logic        io_buffer_full;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int wrCount     = 0;
    int wrBase      = 0;

    logic [7:0] ram [0:1023];

    mem_ctrl #(
        .ADDR_WIDTH (32)
    ) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .mem_din  (memDin),
        .mem_dout (mem_dout),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_done  (if_done),
        .if_data  (if_data),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_len   (ls_len),
        .ls_wdata (ls_wdata),
        .ls_done  (ls_done),
        .ls_rdata (ls_rdata)
`ifdef MEM_CTRL_IO_STALL_EN
        ,
        .io_buffer_full (io_buffer_full)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) memDin <= ram[mem_a[9:0]];

    // Writes are only real when the whole system is running.
    always @(posedge clk_in) begin
        if (mem_wr && rdy_in) begin
            ram[mem_a[9:0]] <= mem_dout;
            wrCount <= wrCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                                 input logic [2:0] len, input logic [31:0] wdata);
        ls_req   = req;
        ls_we    = we;
        ls_addr  = addr;
        ls_len   = len;
        ls_wdata = wdata;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    initial begin
        rdy_in   = 1'b1;
        rst_in   = 1'b0;
        if_req   = 1'b0;
        if_addr  = 32'd0;
        if_flush = 1'b0;
`ifdef MEM_CTRL_IO_STALL_EN
        io_buffer_full = 1'b0;
`endif
        applyStimulus(1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
        ram[10'h104] = 8'h55; ram[10'h105] = 8'h66; ram[10'h106] = 8'h77; ram[10'h107] = 8'h88;
        ram[10'h202] = 8'h5A;
        ram[10'h300] = 8'hA1; ram[10'h301] = 8'hA2; ram[10'h302] = 8'hA3; ram[10'h303] = 8'hA4;
        ram[10'h3FF] = 8'hC3; ram[10'h000] = 8'h3C;

        $display("[TB] reset state");
        #1 rst_in = 1'b1;
        #2;
        checkOutput("rst_mem_a", mem_a, 32'd0);
        checkOutput("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        checkOutput("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        checkOutput("rst_if_done", {31'd0, if_done}, 32'd0);
        checkOutput("rst_ls_done", {31'd0, ls_done}, 32'd0);
        checkOutput("rst_if_data", if_data, 32'd0);
        checkOutput("rst_ls_rdata", ls_rdata, 32'd0);
        @(negedge clk_in) rst_in = 1'b0;
        tick(1);

        $display("[TB] word fetch");
        if_req = 1'b1; if_addr = 32'h100;
        tick(1);
        checkOutput("fetch_addr0", mem_a, 32'h100);
        tick(3);
        checkOutput("fetch_not_early", {31'd0, if_done}, 32'd0);
        tick(1);
        checkOutput("fetch_done", {31'd0, if_done}, 32'd1);
        checkOutput("fetch_data", if_data, 32'h44332211);
        checkOutput("fetch_no_write", wrCount, 32'd0);
        if_req = 1'b0;
        tick(1);
        checkOutput("fetch_done_pulse", {31'd0, if_done}, 32'd0);
        checkOutput("fetch_data_hold", if_data, 32'h44332211);

        $display("[TB] halfword store then byte load");
        applyStimulus(1'b1, 1'b1, 32'h200, 3'd2, 32'hDEADBEEF);
        tick(1);
        checkOutput("st_b0_wr", {31'd0, mem_wr}, 32'd1);
        checkOutput("st_b0_addr", mem_a, 32'h200);
        checkOutput("st_b0_data", {24'd0, mem_dout}, 32'hEF);
        tick(1);
        checkOutput("st_b1_addr", mem_a, 32'h201);
        checkOutput("st_b1_data", {24'd0, mem_dout}, 32'hBE);
        checkOutput("st_not_early", {31'd0, ls_done}, 32'd0);
        tick(1);
        checkOutput("st_done", {31'd0, ls_done}, 32'd1);
        checkOutput("st_wr_low", {31'd0, mem_wr}, 32'd0);
        checkOutput("st_idle_dout", {24'd0, mem_dout}, 32'd0);
        ls_req = 1'b0;
        checkOutput("st_ram200", {24'd0, ram[10'h200]}, 32'hEF);
        checkOutput("st_ram201", {24'd0, ram[10'h201]}, 32'hBE);
        checkOutput("st_ram202", {24'd0, ram[10'h202]}, 32'h5A);
        checkOutput("st_wr_count", wrCount, 32'd2);
        tick(1);
        applyStimulus(1'b1, 1'b0, 32'h201, 3'd1, 32'd0);
        tick(1);
        checkOutput("ldb_addr", mem_a, 32'h201);
        checkOutput("ldb_no_wr", {31'd0, mem_wr}, 32'd0);
        tick(1);
        checkOutput("ldb_done", {31'd0, ls_done}, 32'd1);
        checkOutput("ldb_data", ls_rdata, 32'h000000BE);
        ls_req = 1'b0;
        tick(1);

        $display("[TB] simultaneous requests");
        applyStimulus(1'b1, 1'b0, 32'h100, 3'd4, 32'd0);
        if_req = 1'b1; if_addr = 32'h200;
        tick(1);
        checkOutput("arb_ls_first", mem_a, 32'h100);
        tick(4);
        checkOutput("arb_ls_done", {31'd0, ls_done}, 32'd1);
        checkOutput("arb_ls_data", ls_rdata, 32'h44332211);
        checkOutput("arb_if_waiting", {31'd0, if_done}, 32'd0);
        ls_req = 1'b0;
        tick(1);
        checkOutput("arb_bubble", mem_a, 32'h103);
        tick(1);
        checkOutput("arb_if_start", mem_a, 32'h200);
        tick(4);
        checkOutput("arb_if_done", {31'd0, if_done}, 32'd1);
        checkOutput("arb_if_data", if_data, 32'h005ABEEF);
        tick(1);
        checkOutput("done_no_reaccept", mem_a, 32'h203);
        checkOutput("done_pulse_ends", {31'd0, if_done}, 32'd0);
        if_req = 1'b0;
        tick(1);

        $display("[TB] fetch flush");
        if_req = 1'b1; if_addr = 32'h300;
        tick(2);
        checkOutput("flush_pre_addr", mem_a, 32'h301);
        if_flush = 1'b1;
        tick(1);
        checkOutput("flush_abort_addr", mem_a, 32'h301);
        checkOutput("flush_no_done", {31'd0, if_done}, 32'd0);
        if_flush = 1'b0; if_addr = 32'h104;
        tick(1);
        checkOutput("refetch_start", mem_a, 32'h104);
        tick(3);
        checkOutput("refetch_not_early", {31'd0, if_done}, 32'd0);
        tick(1);
        checkOutput("refetch_done", {31'd0, if_done}, 32'd1);
        checkOutput("refetch_data", if_data, 32'h88776655);
        checkOutput("flush_ram_kept", {24'd0, ram[10'h301]}, 32'hA2);
        checkOutput("flush_no_write", wrCount, 32'd2);
        if_req = 1'b0;
        tick(1);

        $display("[TB] freeze during store");
        applyStimulus(1'b1, 1'b1, 32'h210, 3'd4, 32'h04030201);
        tick(2);
        checkOutput("frz_pre_addr", mem_a, 32'h211);
        checkOutput("frz_pre_data", {24'd0, mem_dout}, 32'h02);
        rdy_in = 1'b0;
        tick(1);
        checkOutput("frz_wr_low", {31'd0, mem_wr}, 32'd0);
        checkOutput("frz_addr_hold", mem_a, 32'h211);
        tick(2);
        rdy_in = 1'b1;
        tick(1);
        checkOutput("frz_reissue_wr", {31'd0, mem_wr}, 32'd1);
        checkOutput("frz_reissue_addr", mem_a, 32'h211);
        checkOutput("frz_reissue_data", {24'd0, mem_dout}, 32'h02);
        tick(3);
        checkOutput("frz_st_done", {31'd0, ls_done}, 32'd1);
        checkOutput("frz_wr_count", wrCount, 32'd6);
        ls_req = 1'b0;
        tick(1);

        $display("[TB] reset mid-load");
        applyStimulus(1'b1, 1'b0, 32'h100, 3'd4, 32'd0);
        tick(2);
        checkOutput("rld_pre_addr", mem_a, 32'h101);
        #2 rst_in = 1'b1;
        #1;
        checkOutput("rld_mem_a", mem_a, 32'd0);
        checkOutput("rld_if_data", if_data, 32'd0);
        checkOutput("rld_ls_rdata", ls_rdata, 32'd0);
        checkOutput("rld_mem_wr", {31'd0, mem_wr}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h210, 3'd4, 32'd0);
        @(negedge clk_in) rst_in = 1'b0;
        tick(4);
        checkOutput("rld_not_early", {31'd0, ls_done}, 32'd0);
        tick(1);
        checkOutput("rld_done", {31'd0, ls_done}, 32'd1);
        checkOutput("store_integrity", ls_rdata, 32'h04030201);
        ls_req = 1'b0;
        tick(1);

        $display("[TB] illegal length runs as word");
        applyStimulus(1'b1, 1'b0, 32'h300, 3'd3, 32'd0);
        tick(4);
        checkOutput("len3_not_early", {31'd0, ls_done}, 32'd0);
        tick(1);
        checkOutput("len3_done", {31'd0, ls_done}, 32'd1);
        checkOutput("len3_data", ls_rdata, 32'hA4A3A2A1);
        ls_req = 1'b0;
        tick(1);

        $display("[TB] address wrap");
        applyStimulus(1'b1, 1'b0, 32'hFFFFFFFF, 3'd2, 32'd0);
        tick(1);
        checkOutput("wrap_addr0", mem_a, 32'hFFFFFFFF);
        tick(1);
        checkOutput("wrap_addr1", mem_a, 32'h00000000);
        tick(1);
        checkOutput("wrap_done", {31'd0, ls_done}, 32'd1);
        checkOutput("wrap_data", ls_rdata, 32'h00003CC3);
        ls_req = 1'b0;
        tick(1);

`ifdef MEM_CTRL_IO_STALL_EN
        $display("[TB] io stall");
        wrBase = wrCount;
        applyStimulus(1'b1, 1'b1, 32'h00030000, 3'd1, 32'h00000099);
        io_buffer_full = 1'b1;
        tick(1);
        checkOutput("io_stall_first", {31'd0, mem_wr}, 32'd0);
        tick(3);
        checkOutput("io_stall_last", {31'd0, mem_wr}, 32'd0);
        io_buffer_full = 1'b0;
        tick(1);
        checkOutput("io_issue", {31'd0, mem_wr}, 32'd1);
        checkOutput("io_not_early", {31'd0, ls_done}, 32'd0);
        tick(1);
        checkOutput("io_done", {31'd0, ls_done}, 32'd1);
        checkOutput("io_single_write", wrCount - wrBase, 32'd1);
        ls_req = 1'b0;
        tick(1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Sole master of the byte-wide, synchronous-read on-board RAM port (8-bit data, one-cycle read latency).
- Arbitrates between the instruction-fetch unit (32-bit reads) and the load/store unit (1/2/4-byte reads and writes).
- Sequences each multi-byte access as consecutive single-byte RAM accesses, little-endian.
- Sits between the CPU core and the RAM/IO address decode.

Parameters:
ADDR_WIDTH, 32, width of request addresses and mem_a.

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-high reset
rdy_in  input  1  global ready; low = freeze all state
mem_din  input  8  RAM read byte (valid the cycle after its address)
mem_dout  output  8  RAM write byte
mem_a  output  ADDR_WIDTH  RAM byte address
mem_wr  output  1  1 = write, 0 = read
if_req  input  1  fetch request (level, held until if_done)
if_addr  input  ADDR_WIDTH  fetch address
if_flush  input  1  abort any in-flight fetch
if_done  output  1  one-cycle pulse: if_data valid
if_data  output  32  fetched word
ls_req  input  1  load/store request (level, held until ls_done)
ls_we  input  1  1 = store, 0 = load
ls_addr  input  ADDR_WIDTH  load/store byte address
ls_len  input  3  byte count: 1, 2 or 4 only
ls_wdata  input  32  store data; low ls_len bytes used
ls_done  output  1  one-cycle pulse: access complete
ls_rdata  output  32  load data, zero-extended

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction): state IDLE, byte counter 0, mem_a=0, mem_dout=0, mem_wr=0, if_done=0, ls_done=0, if_data=0, ls_rdata=0.
- All outputs are registered.
- FSM states: IDLE, IF_RD, LS_RD, LS_WR.
- IDLE transitions:
  - ls_req high → LS_RD or LS_WR, selected by ls_we. LSU has fixed priority over fetch.
  - else if_req high and if_flush low → IF_RD.
  - A request is not accepted in a cycle where if_done or ls_done is high. This gives one mandatory bubble, so a requester still holding req on its done cycle is not re-served.
- Timing, with T = the cycle in which the request is accepted:
  - mem_a = addr+k from edge T+1+k, for k = 0..n-1.
  - Reads: byte k is captured from mem_din on edge T+2+k into bits [8k+7:8k].
  - Writes: mem_wr=1 and mem_dout=wdata[8k+7:8k] alongside mem_a.
  - done pulses on edge T+n+1 for both reads and writes (n=4 for fetch). FSM returns to IDLE on that same edge.
- mem_wr is 0 whenever the FSM is not issuing a write byte.
- When IDLE, mem_a holds its last value and mem_dout=0.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no alignment check.
- Illegal ls_len values (0, 3, >4) are treated as 4.
- if_flush:
  - In IF_RD: abort; next state IDLE; no if_done; partial if_data discarded.
  - In IDLE: blocks fetch acceptance.
  - No effect on LS states; stores always complete.
- rdy_in low: state, counter and outputs hold, except mem_wr is forced 0. The pending byte is re-issued when rdy_in returns high. A read captured in the freeze cycle is discarded and re-captured on resume.
- ls_rdata and if_data hold their value until the next completion of the same kind.

Optional Feature:
MEM_CTRL_IO_STALL_EN:
- Defined: adds input io_buffer_full (1 bit). While it is high, an LS_WR byte whose address has bits [17:16]==2'b11 is not issued: mem_wr=0, the counter holds, and the byte is retried each cycle. done is delayed by the number of stalled cycles.
- Undefined: the port is absent and IO writes issue immediately.

Decomposition:
- Package mem_ctrl_pkg:
  - FSM state encoding.
  - Length constants LEN_B=1, LEN_H=2, LEN_W=4.
  - IO_ADDR_HI=2'b11.
- Sub-module mem_byte_seq: 2-bit byte counter, address incrementer, and read-assembly shift/insert register. Instantiated once and reused for all three transaction states.

Test Plan:
- Reset: RAM[0x100..0x103]=11 22 33 44; if_req at 0x100 → if_done exactly 5 cycles after accept, if_data=0x44332211, mem_wr never high.
- Store: ls_req, ls_we=1, ls_addr=0x200, ls_len=2, ls_wdata=0xDEADBEEF → mem_wr high 2 cycles with bytes EF, BE at 0x200/0x201; ls_done at T+3. A following 1-byte load of 0x201 → ls_rdata=0x000000BE.
- Both requests asserted in the same IDLE cycle → LS served first. Fetch accepted only after the bubble following ls_done. No accept in any done cycle.
- if_flush asserted at T+2 of a fetch → no if_done, FSM IDLE next cycle, RAM contents unchanged. Then a fetch of a new address completes normally.
- rdy_in low for 3 cycles mid-store, then rst_in pulsed mid-load → store resumes with no duplicated or lost byte. Reset forces all outputs 0 immediately, without waiting for a clock edge.
- MEM_CTRL_IO_STALL_EN defined: 1-byte store to 0x30000 with io_buffer_full high for 4 cycles → mem_wr stays 0 for 4 cycles, then a single write occurs; ls_done arrives 4 cycles late.
